// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational 1-bit full subtractor: computes x - y - bin.
// d is the difference bit and bout the borrow into the next bit position.
module serial_sub_fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor. One difference bit per clock is produced LSB-first
// through a single full-subtractor cell with a registered borrow. A
// start/busy/done handshake is exposed to the controlling FSM. The results
// (diff, borrow, overflow) are registered and held until the next operation
// completes or a reset occurs.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             a_msb;
    logic             b_msb;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] res_final;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;

    // A start is only honoured while idle or in the single DONE cycle.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign res_final = {cell_d, res_sh[WIDTH-1:1]};

    serial_sub_fs u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: WIDTH RUN cycles, then one DONE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? RUN : IDLE;
            RUN:     next_state = last_bit ? DONE : RUN;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand capture and the serial datapath: shift one bit through the cell per RUN cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            brw    <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_final;
            brw    <= cell_bout;
            cnt    <= cnt + CW'(1);
        end
    end

    // Result registers, loaded on the final RUN edge so they are valid together with done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            diff_q     <= res_final;
            borrow_q   <= cell_bout;
            overflow_q <= (a_msb != b_msb) && (cell_d != a_msb);
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub at WIDTH=8. Expected values are
// hand-computed constants for each vector.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int assertCount = 0;
    int failCount   = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands with start for one accepting edge; optionally keep start high.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic hold);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
        end
    endtask

    // Run one full operation and check latency, busy length, single done pulse and results.
    task automatic runOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] expDiff, input logic expBorrow, input logic expOvf);
        int doneAt;
        int doneCnt;
        int busyCnt;
        logic [W-1:0] diffAt;
        logic brwAt;
        logic ovfAt;
        doneAt  = 0;
        doneCnt = 0;
        busyCnt = 0;
        diffAt  = '0;
        brwAt   = 1'b0;
        ovfAt   = 1'b0;
        applyStimulus(av, bv, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = n;
                    diffAt = diff;
                    brwAt  = borrow;
                    ovfAt  = overflow;
                end
            end
        end
        checkOutput({tag, "_latency"}, doneAt, 9);
        checkOutput({tag, "_busyCycles"}, busyCnt, 8);
        checkOutput({tag, "_donePulses"}, doneCnt, 1);
        checkOutput({tag, "_diff"}, diffAt, expDiff);
        checkOutput({tag, "_borrow"}, brwAt, expBorrow);
        checkOutput({tag, "_overflow"}, ovfAt, expOvf);
        checkOutput({tag, "_diffHeld"}, diff, expDiff);
    endtask

    // Main sequence of directed scenarios.
    initial begin
        int doneAt;
        int doneCnt;
        int busyCnt;
        int busyErr;
        int badPos;
        logic [W-1:0] diffAt;
        logic snapBusy;
        logic snapDone;
        logic [W-1:0] snapDiff;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_diff", diff, 0);
        checkOutput("reset_borrow", borrow, 0);
        checkOutput("reset_overflow", overflow, 0);
        reset_n = 1'b1;

        runOp("basic", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        runOp("neg", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        runOp("zeroMinusOne", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        runOp("ovfPos", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        runOp("ovfNeg", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        runOp("equal", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);

        // start re-asserted on the 3rd RUN cycle must be ignored
        doneAt  = 0;
        doneCnt = 0;
        diffAt  = '0;
        applyStimulus(8'h5A, 8'h23, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = n;
                    diffAt = diff;
                end
            end
            if (n == 2) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h02;
            end else if (n == 3) begin
                start = 1'b0;
            end
        end
        checkOutput("ignore_latency", doneAt, 9);
        checkOutput("ignore_donePulses", doneCnt, 1);
        checkOutput("ignore_diff", diffAt, 8'h37);

        // reset on the 4th RUN cycle aborts the operation
        doneCnt  = 0;
        busyCnt  = 0;
        snapBusy = 1'b1;
        snapDone = 1'b1;
        snapDiff = '1;
        applyStimulus(8'h5A, 8'h23, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (n >= 4 && busy) busyCnt++;
            if (n == 3) begin
                reset_n = 1'b0;
            end else if (n == 4) begin
                snapBusy = busy;
                snapDone = done;
                snapDiff = diff;
                reset_n  = 1'b1;
            end
        end
        checkOutput("abort_busy", snapBusy, 0);
        checkOutput("abort_done", snapDone, 0);
        checkOutput("abort_diff", snapDiff, 0);
        checkOutput("abort_noDone", doneCnt, 0);
        checkOutput("abort_staysIdle", busyCnt, 0);
        runOp("recover", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        // start held high: back-to-back operations every 9 cycles
        doneCnt = 0;
        busyErr = 0;
        badPos  = 0;
        applyStimulus(8'h05, 8'h03, 1'b1);
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if ((n % 9) != 0) badPos++;
                checkOutput("b2b_diff", diff, 8'h02);
            end
            if (busy == done) busyErr++;
            if (n == 27) start = 1'b0;
        end
        checkOutput("b2b_donePulses", doneCnt, 3);
        checkOutput("b2b_donePosition", badPos, 0);
        checkOutput("b2b_busyPattern", busyErr, 0);
        @(negedge clk);
        checkOutput("b2b_idleAfter", {busy, done}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
